// File: rtl/alert_panel_gen.sv
// rtl/alert_panel_gen.sv - alert panel: debounced add/clear buttons, saturating level, blinking alarm
//
// Purpose: two raw push buttons drive a saturating level counter shown on a
// thermometer LED bar. At full scale the alarm flag rises and the alarm LED
// blinks. One clock domain; a tick-enable divider paces debounce sampling and
// blinking.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn_add      raw add button (asynchronous, bouncing)
//   btn_clr      raw clear button (asynchronous, bouncing)
//   count        current level 0..LEVELS
//   led_level    thermometer bar, led_level[i] = (count > i)
//   alarm        high while at full scale
//   alarm_blink  blinking alarm LED, low outside alarm
module alert_panel_gen #(
  parameter int CLK_DIV        = 50000,
  parameter int DEB_N          = 4,
  parameter int LEVELS         = 4,
  parameter int BLINK_TICKS    = 250,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         btn_add,
  input  logic                         btn_clr,
  output logic [$clog2(LEVELS+1)-1:0]  count,
  output logic [LEVELS-1:0]            led_level,
  output logic                         alarm,
  output logic                         alarm_blink
);

  localparam int CW = $clog2(LEVELS + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = $clog2(DEB_N + 1);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNTING,
    S_ALARM
  } state_t;

  // Sample tick: one clk wide pulse every CLK_DIV cycles (every cycle when CLK_DIV=1).
  logic [DW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Button path, bit 0 = add, bit 1 = clear.
  logic [1:0]    raw;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    sample;
  logic [1:0]    stable_q;
  logic [1:0]    stable_prev_q;
  logic [1:0]    press_q;
  logic [RW-1:0] run_q [2];

  assign raw    = {btn_clr, btn_add};
  assign sample = BTN_ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      press_q       <= '0;
      run_q[0]      <= '0;
      run_q[1]      <= '0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      // Rising edge of the debounced level only; releases produce no event.
      press_q       <= stable_q & ~stable_prev_q;
      if (tick) begin
        for (int i = 0; i < 2; i++) begin
          if (sample[i] != stable_q[i]) begin
            // The DEB_N-th consecutive differing sample commits the new level.
            if (run_q[i] == RW'(DEB_N - 1)) begin
              stable_q[i] <= sample[i];
              run_q[i]    <= '0;
            end else begin
              run_q[i]    <= run_q[i] + RW'(1);
            end
          end else begin
            run_q[i] <= '0;
          end
        end
      end
    end
  end

  // Controller: level counter, alarm flag and blink generator.
  state_t        state_q;
  logic [CW-1:0] count_q;
  logic          alarm_q;
  logic          blink_q;
  logic [BW-1:0] bcnt_q;
  logic          add_p;
  logic          clr_p;

  assign add_p = press_q[0];
  assign clr_p = press_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      alarm_q <= 1'b0;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else if (clr_p) begin
      // Clear wins over a simultaneous add.
      state_q <= S_IDLE;
      count_q <= '0;
      alarm_q <= 1'b0;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_COUNTING: begin
          if (add_p) begin
            count_q <= count_q + CW'(1);
            if (count_q == CW'(LEVELS - 1)) begin
              state_q <= S_ALARM;
              alarm_q <= 1'b1;
              blink_q <= 1'b1;
              bcnt_q  <= '0;
            end else begin
              state_q <= S_COUNTING;
            end
          end
        end
        S_ALARM: begin
          // Adds are ignored here, so the level saturates at LEVELS.
          if (tick) begin
            if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
              bcnt_q  <= '0;
              blink_q <= ~blink_q;
            end else begin
              bcnt_q  <= bcnt_q + BW'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    led_level = '0;
    for (int i = 0; i < LEVELS; i++) begin
      led_level[i] = (count_q > CW'(i));
    end
  end

  assign count       = count_q;
  assign alarm       = alarm_q;
  assign alarm_blink = blink_q;

endmodule

// File: tb/tb_alert_panel_gen.sv
// tb/tb_alert_panel_gen.sv - self-checking bench for alert_panel_gen
module tb_alert_panel_gen;

  localparam int DEB_N  = 3;
  localparam int LEVELS = 4;
  localparam int BT     = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_add = 1'b0;
  logic       btn_clr = 1'b0;
  logic [2:0] count;
  logic [3:0] led_level;
  logic       alarm;
  logic       alarm_blink;

  int n_checks = 0;
  int n_fail   = 0;

  alert_panel_gen #(
    .CLK_DIV(1), .DEB_N(DEB_N), .LEVELS(LEVELS), .BLINK_TICKS(BT), .BTN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_add(btn_add), .btn_clr(btn_clr),
    .count(count), .led_level(led_level), .alarm(alarm), .alarm_blink(alarm_blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: edge-indexed. A button level seen at edge k reaches the
  // debouncer two edges later; an accepted press changes the level two edges
  // after acceptance. Blink phase is derived from edges elapsed since alarm entry.
  int mcount = 0;
  int k = 0;
  int entry = 0;
  int add_due = -1;
  int clr_due = -1;
  bit ma_d1, ma_d2, mc_d1, mc_d2, mst_a, mst_c;
  int mrun_a, mrun_c;

  task automatic deb(input bit samp, inout bit st, inout int run, output bit rise);
    rise = 1'b0;
    if (samp != st) begin
      run++;
      if (run == DEB_N) begin
        st   = samp;
        run  = 0;
        rise = samp;
      end
    end else begin
      run = 0;
    end
  endtask

  initial begin
    bit sa, sc, ra, rc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mcount = 0; add_due = -1; clr_due = -1;
        ma_d1 = 0; ma_d2 = 0; mc_d1 = 0; mc_d2 = 0;
        mst_a = 0; mst_c = 0; mrun_a = 0; mrun_c = 0;
      end else begin
        k++;
        if (clr_due == k) begin
          mcount = 0;
        end else if (add_due == k && mcount < LEVELS) begin
          mcount++;
          if (mcount == LEVELS) entry = k;
        end
        sa = ma_d2; ma_d2 = ma_d1; ma_d1 = btn_add;
        sc = mc_d2; mc_d2 = mc_d1; mc_d1 = btn_clr;
        deb(sa, mst_a, mrun_a, ra);
        deb(sc, mst_c, mrun_c, rc);
        if (ra) add_due = k + 2;
        if (rc) clr_due = k + 2;
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    int el, eb;
    forever begin
      @(negedge clk);
      el = 0;
      for (int i = 0; i < LEVELS; i++) if (mcount > i) el |= (1 << i);
      eb = (mcount == LEVELS) ? ((((k - entry) / BT) % 2) == 0 ? 1 : 0) : 0;
      chk("model_count", int'(count), mcount);
      chk("model_led", int'(led_level), el);
      chk("model_alarm", int'(alarm), (mcount == LEVELS) ? 1 : 0);
      chk("model_blink", int'(alarm_blink), eb);
    end
  end

  task automatic press(input bit a, input bit c);
    @(negedge clk);
    btn_add = a;
    btn_clr = c;
    repeat (5) @(negedge clk);
    btn_add = 1'b0;
    btn_clr = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [5:0] exp_bl;
    exp_bl = 6'b110011;

    // 1: reset with toggling buttons
    repeat (8) begin
      @(negedge clk);
      btn_add = ~btn_add;
      btn_clr = 1'($urandom_range(0, 1));
    end
    chk("rst_count", int'(count), 0);
    chk("rst_led", int'(led_level), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_blink", int'(alarm_blink), 0);
    @(negedge clk);
    btn_add = 1'b0;
    btn_clr = 1'b0;
    rst_n   = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_count", int'(count), 0);

    // 2: bounce then clean hold
    @(negedge clk);
    btn_add = 1'b1;
    repeat (2) @(negedge clk);
    btn_add = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_count", int'(count), 0);
    @(negedge clk);
    btn_add = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("latency_e6_count", int'(count), 0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_e7_count", int'(count), 1);
    chk("latency_e7_led", int'(led_level), 4'b0001);
    repeat (3) @(negedge clk);
    btn_add = 1'b0;
    repeat (8) @(negedge clk);
    chk("single_inc", int'(count), 1);

    // 3: clear, then four clean adds into alarm, blink pattern, saturation
    press(1'b0, 1'b1);
    chk("clear_before_fill", int'(count), 0);
    repeat (3) press(1'b1, 1'b0);
    chk("three_adds", int'(count), 3);
    @(negedge clk);
    btn_add = 1'b1;
    repeat (5) @(negedge clk);
    btn_add = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("blink_seq", int'(alarm_blink), int'(exp_bl[5-i]));
    end
    chk("full_count", int'(count), 4);
    chk("full_led", int'(led_level), 4'b1111);
    chk("full_alarm", int'(alarm), 1);
    repeat (4) @(negedge clk);
    press(1'b1, 1'b0);
    chk("saturate", int'(count), 4);

    // 4: clear from alarm, checked at the exact edge
    @(negedge clk);
    btn_clr = 1'b1;
    repeat (5) @(negedge clk);
    btn_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_clr_alarm", int'(alarm), 1);
    @(posedge clk);
    @(negedge clk);
    chk("clr_count", int'(count), 0);
    chk("clr_led", int'(led_level), 0);
    chk("clr_alarm", int'(alarm), 0);
    chk("clr_blink", int'(alarm_blink), 0);
    repeat (8) @(negedge clk);

    // 5: simultaneous add and clear at level 2
    repeat (2) press(1'b1, 1'b0);
    chk("two_adds", int'(count), 2);
    press(1'b1, 1'b1);
    chk("clr_wins", int'(count), 0);

    // 6: asynchronous reset mid-blink, add held through release
    repeat (4) press(1'b1, 1'b0);
    chk("alarm_again", int'(alarm), 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    btn_add = 1'b1;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_led", int'(led_level), 0);
    chk("async_rst_alarm", int'(alarm), 0);
    chk("async_rst_blink", int'(alarm_blink), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("held_e6_count", int'(count), 0);
    @(posedge clk);
    @(negedge clk);
    chk("held_e7_count", int'(count), 1);
    repeat (20) @(negedge clk);
    chk("held_once", int'(count), 1);
    btn_add = 1'b0;
    repeat (8) @(negedge clk);
    chk("held_release", int'(count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
